spike_event_recorder: RTL and testbench
=======================================

# spike_event_recorder

Downstream of the Izhikevich neuron core. On every simulation step it samples the core's spike flag and membrane voltage. Each spike becomes a timestamped event in a DEPTH-entry FIFO, which host or router logic drains over a valid/ready interface. The block also keeps a free-running step counter, a total spike count and an overflow indicator.

## Interface
- N, 32: fixed-point word width of voltage (signed, Q fractional bits)
- Q, 16: fractional bits; carried for consistency, no arithmetic depends on it
- DEPTH, 16: FIFO entries; power of two, ≥2
- TS_W, 16: timestamp / counter width
- clk  in  1: single clock, all logic on posedge
- rst  in  1: synchronous, active-high reset
- sample  in  1: one-cycle strobe; the core's is_spiking/voltage reflect a newly completed step this cycle
- is_spiking  in  1: core spike flag
- voltage  in  N: core membrane voltage, stored with the event
- ev_valid  out  1: FIFO non-empty; head event presented
- ev_ready  in  1: consumer accepts head event when ev_valid & ev_ready
- ev_time  out  TS_W: step index of head event
- ev_voltage  out  N: voltage captured with head event
- occupancy  out  $clog2(DEPTH)+1: entries held
- spike_count  out  TS_W: total spikes seen, saturating
- overflow  out  1: sticky; a spike was dropped because FIFO full

## Operation
- step_ctr (TS_W, internal): increments by 1 on every sample; wraps 2^TS_W−1 → 0.
- Push condition: sample & is_spiking. The pushed entry is {step_ctr value before increment, voltage}. The first sampled step therefore has timestamp 0.
- spike_count increments on every push condition, including dropped ones. It saturates at 2^TS_W−1.
- Pop condition: ev_valid & ev_ready. This advances the read pointer.
- FIFO is first-word-fall-through. ev_time/ev_voltage are driven from mem[rd_ptr]. They are undefined (no requirement) while ev_valid=0.
- Full (occupancy==DEPTH) with push and no pop: the event is dropped, overflow is set to 1, and mem, pointers and occupancy are unchanged.
- Full with push and pop in the same cycle: both are accepted and occupancy stays DEPTH. No overflow.
- Empty with push and pop in the same cycle: the pop is ignored because ev_valid=0. The push is accepted.
- Pointers are $clog2(DEPTH) bits and wrap naturally. occupancy tracks the fill level separately.
- overflow clears only on rst.
- sample with is_spiking=0: only step_ctr advances.
- ev_ready is ignored when ev_valid=0.

## Timing
- Push at posedge k: ev_valid=1 and the head data are visible after edge k. This is 1-cycle latency from the sample strobe.
- Pop at posedge k: the next head, or ev_valid=0, is visible after edge k.
- occupancy, spike_count and overflow are registered and update at the same edge as the causing event.
- Reset, synchronous, takes priority over all same-cycle events:
  - ev_valid=0, occupancy=0, spike_count=0, overflow=0.
  - step_ctr=0 and both pointers=0.
  - FIFO contents are not cleared.
- Reset mid-operation discards all held events. sample in the reset cycle is ignored.
- Back-to-back samples on consecutive cycles are supported at full rate.

## Configuration
- SPIKE_RECORDER_RATE_EN defined:
  - Adds parameter WINDOW (default 100) and outputs rate (TS_W) and rate_valid (1).
  - An internal window counter counts samples. Spikes within the window are accumulated, saturating.
  - On the sample that completes WINDOW samples, rate is loaded with the accumulated count, including that sample's spike. rate_valid pulses for 1 cycle after that edge. The accumulator and window counter then restart at 0.
  - Reset zeros rate, rate_valid, the accumulator and the window counter.
- Undefined: the rate ports, WINDOW and all rate logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then 5 samples with is_spiking pattern 0,0,1,0,1 and voltage 0x001E0000 on the spikes, with ev_ready=0:
  - occupancy=2.
  - Head ev_time=2, ev_voltage=0x001E0000.
  - spike_count=2.
- Drain with ev_ready=1 held: ev_time reads 2 then 4, then ev_valid=0 and occupancy=0.
- DEPTH=16 and 20 consecutive spiking samples with no pop:
  - occupancy=16, overflow=1, spike_count=20.
  - Drained timestamps are 0..15.
- At full, assert sample&is_spiking and ev_ready in the same cycle:
  - occupancy stays 16 and overflow stays 0.
  - Tail timestamp is 16.
- TS_W=4 with 18 samples, spike on sample index 17: ev_time=1, showing wrap.
- With SPIKE_RECORDER_RATE_EN, WINDOW=10, spikes on 3 of the first 10 samples: rate=3 and rate_valid is high for exactly 1 cycle after the 10th sample. Then assert rst mid-window: rate=0.

Source files
------------

// File: rtl/spike_event_recorder.sv
// Timestamped spike-event FIFO (first-word-fall-through) with step/spike counters.
// Optional windowed spike-rate output enabled by defining SPIKE_RECORDER_RATE_EN.
module spike_event_recorder #(
   parameter int unsigned N      = 32,
   parameter int unsigned Q      = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned TS_W   = 16
`ifdef SPIKE_RECORDER_RATE_EN
   ,
   parameter int unsigned WINDOW = 100
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample,
   input  logic                       is_spiking,
   input  logic [N-1:0]               voltage,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [TS_W-1:0]            ev_time,
   output logic [N-1:0]               ev_voltage,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [TS_W-1:0]            spike_count,
   output logic                       overflow
`ifdef SPIKE_RECORDER_RATE_EN
   ,
   output logic [TS_W-1:0]            rate,
   output logic                       rate_valid
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;
   localparam int unsigned DW = TS_W + N;

   if (Q >= N || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2) begin : g_param_check
      $error("spike_event_recorder: invalid Q or DEPTH");
   end

   logic [DW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [TS_W-1:0] step_ctr_q, step_ctr_d, spike_count_q, spike_count_d;
   logic            overflow_q, overflow_d;
   logic            push, pop, full, accept;
   logic [DW-1:0]   head_word;

   assign push      = sample & is_spiking;
   assign full      = (occ_q == OW'(DEPTH));
   assign pop       = ev_valid & ev_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept    = push & (~full | pop);
   assign head_word = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      occ_d         = occ_q;
      step_ctr_d    = step_ctr_q;
      spike_count_d = spike_count_q;
      overflow_d    = overflow_q;
      if (sample) step_ctr_d = step_ctr_q + TS_W'(1);
      if (push && spike_count_q != '1) spike_count_d = spike_count_q + TS_W'(1);
      if (push && !accept) overflow_d = 1'b1;
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
         step_ctr_q    <= '0;
         spike_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
         step_ctr_q    <= step_ctr_d;
         spike_count_q <= spike_count_d;
         overflow_q    <= overflow_d;
      end
   end

   // Storage is deliberately not reset; the pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (!rst && accept) mem_q[wr_ptr_q] <= {step_ctr_q, voltage};
   end

   assign ev_valid    = (occ_q != '0);
   assign ev_time     = head_word[DW-1:N];
   assign ev_voltage  = head_word[N-1:0];
   assign occupancy   = occ_q;
   assign spike_count = spike_count_q;
   assign overflow    = overflow_q;

`ifdef SPIKE_RECORDER_RATE_EN
   localparam int unsigned WW = $clog2(WINDOW + 1);

   logic [WW-1:0]   win_q, win_d;
   logic [TS_W-1:0] acc_q, acc_d, rate_q, rate_d, acc_sum;
   logic            rate_valid_q, rate_valid_d;

   always_comb begin
      win_d        = win_q;
      acc_d        = acc_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      acc_sum      = acc_q;
      if (push && acc_q != '1) acc_sum = acc_q + TS_W'(1);
      if (sample) begin
         if (win_q == WW'(WINDOW - 1)) begin
            rate_d       = acc_sum;
            rate_valid_d = 1'b1;
            win_d        = '0;
            acc_d        = '0;
         end else begin
            win_d = win_q + WW'(1);
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q        <= '0;
         acc_q        <= '0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
      end else begin
         win_q        <= win_d;
         acc_q        <= acc_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = rate_valid_q;
`endif

endmodule

// File: tb/tb_spike_event_recorder.sv
// Directed self-checking bench for spike_event_recorder; a second instance with
// TS_W=4 shares the stimulus to exercise timestamp wrap and counter saturation.
module tb_spike_event_recorder;

   logic        clk = 1'b0;
   logic        rst, sample, is_spiking, ev_ready;
   logic [31:0] voltage;

   logic        ev_valid, overflow, s_ev_valid, s_overflow;
   logic [15:0] ev_time, spike_count;
   logic [3:0]  s_ev_time, s_spike_count;
   logic [31:0] ev_voltage, s_ev_voltage;
   logic [4:0]  occupancy, s_occupancy;
`ifdef SPIKE_RECORDER_RATE_EN
   logic [15:0] rate;
   logic [3:0]  s_rate;
   logic        rate_valid, s_rate_valid;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spike_event_recorder #(
      .N(32), .Q(16), .DEPTH(16), .TS_W(16)
`ifdef SPIKE_RECORDER_RATE_EN
      , .WINDOW(10)
`endif
   ) u_dut (
      .clk(clk), .rst(rst), .sample(sample), .is_spiking(is_spiking), .voltage(voltage),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time), .ev_voltage(ev_voltage),
      .occupancy(occupancy), .spike_count(spike_count), .overflow(overflow)
`ifdef SPIKE_RECORDER_RATE_EN
      , .rate(rate), .rate_valid(rate_valid)
`endif
   );

   spike_event_recorder #(
      .N(32), .Q(16), .DEPTH(16), .TS_W(4)
`ifdef SPIKE_RECORDER_RATE_EN
      , .WINDOW(10)
`endif
   ) u_small (
      .clk(clk), .rst(rst), .sample(sample), .is_spiking(is_spiking), .voltage(voltage),
      .ev_valid(s_ev_valid), .ev_ready(ev_ready), .ev_time(s_ev_time),
      .ev_voltage(s_ev_voltage), .occupancy(s_occupancy), .spike_count(s_spike_count),
      .overflow(s_overflow)
`ifdef SPIKE_RECORDER_RATE_EN
      , .rate(s_rate), .rate_valid(s_rate_valid)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are read at that same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sample = 1'b0; is_spiking = 1'b0; ev_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic step(input logic spk, input logic [31:0] v);
      sample = 1'b1; is_spiking = spk; voltage = v;
      tick();
      sample = 1'b0; is_spiking = 1'b0;
   endtask

   initial begin
      bit [4:0] pat;
      rst = 1'b0; sample = 1'b0; is_spiking = 1'b0; ev_ready = 1'b0; voltage = '0;
      tick();
      do_reset();
      check_eq("reset_valid", 64'(ev_valid), 64'd0);
      check_eq("reset_occ", 64'(occupancy), 64'd0);
      check_eq("reset_count", 64'(spike_count), 64'd0);
      check_eq("reset_ovf", 64'(overflow), 64'd0);

      // Pattern 0,0,1,0,1 (index 0 first)
      pat = 5'b10100;
      for (int i = 0; i < 5; i++) step(pat[i], pat[i] ? 32'h001E_0000 : 32'h0000_1234);
      check_eq("pat_occ", 64'(occupancy), 64'd2);
      check_eq("pat_valid", 64'(ev_valid), 64'd1);
      check_eq("pat_time", 64'(ev_time), 64'd2);
      check_eq("pat_volt", 64'(ev_voltage), 64'h001E_0000);
      check_eq("pat_count", 64'(spike_count), 64'd2);

      ev_ready = 1'b1;
      tick();
      check_eq("drain_time2", 64'(ev_time), 64'd4);
      check_eq("drain_valid2", 64'(ev_valid), 64'd1);
      tick();
      check_eq("drain_empty", 64'(ev_valid), 64'd0);
      check_eq("drain_occ", 64'(occupancy), 64'd0);
      ev_ready = 1'b0;

      // 20 back-to-back spikes into a 16-deep FIFO
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 32'(i) + 32'h100);
      check_eq("full_occ", 64'(occupancy), 64'd16);
      check_eq("full_ovf", 64'(overflow), 64'd1);
      check_eq("full_count", 64'(spike_count), 64'd20);
      check_eq("small_sat_count", 64'(s_spike_count), 64'd15);
      check_eq("small_ovf", 64'(s_overflow), 64'd1);
      ev_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("ovf_drain_time%0d", i), 64'(ev_time), 64'(i));
         check_eq($sformatf("ovf_drain_volt%0d", i), 64'(ev_voltage), 64'(i + 32'h100));
         tick();
      end
      check_eq("ovf_drain_empty", 64'(ev_valid), 64'd0);
      check_eq("ovf_sticky", 64'(overflow), 64'd1);
      ev_ready = 1'b0;

      // Simultaneous push and pop while full
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i));
      check_eq("fill16_occ", 64'(occupancy), 64'd16);
      ev_ready = 1'b1;
      step(1'b1, 32'hBEEF);
      ev_ready = 1'b0;
      check_eq("pushpop_occ", 64'(occupancy), 64'd16);
      check_eq("pushpop_ovf", 64'(overflow), 64'd0);
      check_eq("pushpop_head", 64'(ev_time), 64'd1);
      ev_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check_eq($sformatf("pushpop_time%0d", i), 64'(ev_time), 64'(i));
         tick();
      end
      check_eq("pushpop_tail_volt_gone", 64'(ev_valid), 64'd0);
      ev_ready = 1'b0;

      // Empty FIFO: push with ev_ready high is still accepted
      do_reset();
      ev_ready = 1'b1;
      step(1'b1, 32'h55);
      ev_ready = 1'b0;
      check_eq("empty_pushpop_occ", 64'(occupancy), 64'd1);
      check_eq("empty_pushpop_volt", 64'(ev_voltage), 64'h55);

      // Timestamp wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 18; i++) step(i == 17, 32'h77);
      check_eq("wrap_small_time", 64'(s_ev_time), 64'd1);
      check_eq("wrap_wide_time", 64'(ev_time), 64'd17);
      check_eq("wrap_small_occ", 64'(s_occupancy), 64'd1);

      // Reset mid-operation discards events and ignores same-cycle sample
      rst = 1'b1; sample = 1'b1; is_spiking = 1'b1;
      tick();
      rst = 1'b0; sample = 1'b0; is_spiking = 1'b0;
      check_eq("midrst_occ", 64'(occupancy), 64'd0);
      check_eq("midrst_count", 64'(spike_count), 64'd0);
      step(1'b1, 32'h9);
      check_eq("midrst_first_ts", 64'(ev_time), 64'd0);

`ifdef SPIKE_RECORDER_RATE_EN
      do_reset();
      for (int i = 0; i < 9; i++) step(i == 1 || i == 4 || i == 7, 32'h1);
      check_eq("rate_pre_valid", 64'(rate_valid), 64'd0);
      step(1'b0, 32'h1);
      check_eq("rate_val", 64'(rate), 64'd3);
      check_eq("rate_valid_pulse", 64'(rate_valid), 64'd1);
      tick();
      check_eq("rate_valid_drop", 64'(rate_valid), 64'd0);
      check_eq("rate_hold", 64'(rate), 64'd3);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h1);
      do_reset();
      check_eq("rate_rst", 64'(rate), 64'd0);
      check_eq("rate_valid_rst", 64'(rate_valid), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
